// File: rtl/phys_reg_allocator.sv
// Circular free list of physical register indices for rename checkout / ROB checkin.
// Optional ALLOC_CHECK_EN adds an is_free bitmap that rejects double frees.
module phys_reg_allocator #(
  parameter  int NUM_PREG = 32,
  parameter  int NUM_AREG = 16,
  localparam int PW       = $clog2(NUM_PREG),
  localparam int CAP      = NUM_PREG - NUM_AREG,
  localparam int CW       = $clog2(CAP + 1)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          checkout,
  output logic [PW-1:0] out,
  output logic          avail,
  input  logic          checkin,
  input  logic [PW-1:0] in,
  output logic [CW-1:0] free_count,
  output logic          underflow_err,
  output logic          overflow_err,
  output logic          double_free
);

  localparam int HW = (CAP > 1) ? $clog2(CAP) : 1;
  localparam logic [CW-1:0] CAP_C = CW'(CAP);

  logic [PW-1:0] entry_r [CAP];
  logic [HW-1:0] head_r;
  logic [HW-1:0] tail_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic          underflow_r;
  logic          overflow_r;
  logic          avail_s;
  logic          co_acc_s;
  logic          ci_space_s;
  logic          ci_dup_s;
  logic          ci_acc_s;

  // CAP need not be a power of two, so wrap by explicit compare
  function automatic logic [HW-1:0] wrap_inc(input logic [HW-1:0] p);
    if (p == HW'(CAP - 1)) begin
      return {HW{1'b0}};
    end else begin
      return p + HW'(1);
    end
  endfunction

`ifdef ALLOC_CHECK_EN
  logic [NUM_PREG-1:0] is_free_r;
  logic                dfree_r;

  // Duplicate return: index already free and not being handed out this cycle
  always_comb begin
    ci_dup_s = 1'b0;
    if (is_free_r[in] && !(co_acc_s && (out == in))) begin
      ci_dup_s = 1'b1;
    end else begin
      ci_dup_s = 1'b0;
    end
  end

  // Ownership bitmap and sticky double-free flag; checkin set wins over checkout clear
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_PREG; i++) begin
        is_free_r[i] <= (i >= NUM_AREG);
      end
      dfree_r <= 1'b0;
    end else begin
      if (co_acc_s) is_free_r[out] <= 1'b0;
      if (ci_acc_s) is_free_r[in] <= 1'b1;
      dfree_r <= dfree_r | (checkin & ci_dup_s);
    end
  end

  assign double_free = dfree_r;
`else
  assign ci_dup_s    = 1'b0;
  assign double_free = 1'b0;
`endif

  assign avail_s = (count_r != {CW{1'b0}});

  // Acceptance: a same-cycle checkout frees a slot for a checkin into a full list
  always_comb begin
    co_acc_s   = checkout & avail_s;
    ci_space_s = (count_r != CAP_C) | co_acc_s;
    ci_acc_s   = checkin & ci_space_s & ~ci_dup_s;
  end

  // Occupancy update
  always_comb begin
    count_nxt_s = count_r;
    case ({co_acc_s, ci_acc_s})
      2'b10:   count_nxt_s = count_r - CW'(1);
      2'b01:   count_nxt_s = count_r + CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage, pointers, count and sticky error flags
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < CAP; i++) begin
        entry_r[i] <= PW'(NUM_AREG + i);
      end
      head_r      <= {HW{1'b0}};
      tail_r      <= {HW{1'b0}};
      count_r     <= CAP_C;
      underflow_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      if (ci_acc_s) begin
        entry_r[tail_r] <= in;
        tail_r          <= wrap_inc(tail_r);
      end
      if (co_acc_s) head_r <= wrap_inc(head_r);
      count_r     <= count_nxt_s;
      underflow_r <= underflow_r | (checkout & ~avail_s);
      overflow_r  <= overflow_r | (checkin & ~ci_space_s);
    end
  end

  assign out           = entry_r[head_r];
  assign avail         = avail_s;
  assign free_count    = count_r;
  assign underflow_err = underflow_r;
  assign overflow_err  = overflow_r;

endmodule

// File: tb/tb_phys_reg_allocator.sv
// Directed bench for phys_reg_allocator (default 32/16 configuration).
module tb_phys_reg_allocator;

  logic       clk;
  logic       n_rst;
  logic       checkout;
  logic [4:0] out;
  logic       avail;
  logic       checkin;
  logic [4:0] in;
  logic [4:0] free_count;
  logic       underflow_err;
  logic       overflow_err;
  logic       double_free;

  int n_vec;
  int n_miss;

  phys_reg_allocator dut (
    .clk(clk), .n_rst(n_rst), .checkout(checkout), .out(out), .avail(avail),
    .checkin(checkin), .in(in), .free_count(free_count),
    .underflow_err(underflow_err), .overflow_err(overflow_err),
    .double_free(double_free)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic co, input logic ci, input logic [4:0] idx);
    checkout = co;
    checkin  = ci;
    in       = idx;
    @(posedge clk);
    #1;
    checkout = 1'b0;
    checkin  = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_out"},   32'(out), 32'd16);
    check_val({tag, "_avail"}, 32'(avail), 32'd1);
    check_val({tag, "_fc"},    32'(free_count), 32'd16);
    check_val({tag, "_uf"},    32'(underflow_err), 32'd0);
    check_val({tag, "_of"},    32'(overflow_err), 32'd0);
    check_val({tag, "_df"},    32'(double_free), 32'd0);
  endtask

  task automatic do_reset();
    checkout = 1'b0;
    checkin  = 1'b0;
    in       = 5'd0;
    n_rst    = 1'b0;
    #3;
    @(negedge clk);
    n_rst = 1'b1;
    #1;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;

    // 1: reset and idle
    do_reset();
    repeat (3) step(1'b0, 1'b0, 5'd0);
    check_reset_state("reset");

    // 2: drain all 16, then underflow
    for (int i = 0; i < 16; i++) begin
      check_val("drain_out", 32'(out), 32'(16 + i));
      step(1'b1, 1'b0, 5'd0);
    end
    check_val("empty_avail", 32'(avail), 32'd0);
    check_val("empty_fc", 32'(free_count), 32'd0);
    step(1'b1, 1'b0, 5'd0);
    check_val("uf_flag", 32'(underflow_err), 32'd1);
    check_val("uf_fc", 32'(free_count), 32'd0);
    check_val("uf_avail", 32'(avail), 32'd0);

    // 3: empty + checkin + checkout: no bypass, checkin taken
    step(1'b1, 1'b1, 5'd5);
    check_val("nobyp_fc", 32'(free_count), 32'd1);
    check_val("nobyp_out", 32'(out), 32'd5);
    step(1'b0, 1'b1, 5'd9);
    check_val("ci9_fc", 32'(free_count), 32'd2);
    check_val("ci9_out", 32'(out), 32'd5);
    step(1'b1, 1'b0, 5'd0);
    check_val("co5_out", 32'(out), 32'd9);
    check_val("co5_fc", 32'(free_count), 32'd1);

    // 4: full list, checkin with same-cycle checkout, then without
    do_reset();
    step(1'b1, 1'b1, 5'd3);
    check_val("full_swap_fc", 32'(free_count), 32'd16);
    check_val("full_swap_of", 32'(overflow_err), 32'd0);
    step(1'b0, 1'b1, 5'd7);
    check_val("ovf_flag", 32'(overflow_err), 32'd1);
    check_val("ovf_fc", 32'(free_count), 32'd16);
    for (int i = 0; i < 15; i++) begin
      check_val("ovf_order", 32'(out), 32'(17 + i));
      step(1'b1, 1'b0, 5'd0);
    end
    check_val("ovf_last", 32'(out), 32'd3);

    // 5: tail/head wrap
    do_reset();
    repeat (16) step(1'b1, 1'b0, 5'd0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 5'(i));
    check_val("wrap_fc", 32'(free_count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check_val("wrap_out", 32'(out), 32'(i));
      step(1'b1, 1'b0, 5'd0);
    end
    check_val("wrap_uf", 32'(underflow_err), 32'd0);
    check_val("wrap_of", 32'(overflow_err), 32'd0);
    check_val("wrap_avail", 32'(avail), 32'd0);

    // 6: duplicate checkin of a still-free register
    do_reset();
    step(1'b1, 1'b0, 5'd0);
    check_val("dup_pre_fc", 32'(free_count), 32'd15);
    step(1'b0, 1'b1, 5'd20);
`ifdef ALLOC_CHECK_EN
    check_val("dup_fc", 32'(free_count), 32'd15);
    check_val("dup_df", 32'(double_free), 32'd1);
`else
    check_val("dup_fc", 32'(free_count), 32'd16);
    check_val("dup_df", 32'(double_free), 32'd0);
`endif
    check_val("dup_out", 32'(out), 32'd17);

    // mid-sequence async reset restores reset outputs at once
    step(1'b1, 1'b0, 5'd0);
    checkin = 1'b1;
    in      = 5'd2;
    #2;
    n_rst = 1'b0;
    #1;
    check_reset_state("midrst");
    checkin = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    step(1'b0, 1'b0, 5'd0);
    check_reset_state("postrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
